// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 period encoding used by the transmit and receive paths.
package h14tx_pkg;

    typedef enum logic [2:0] {
        Control            = 3'd0,
        VideoPreamble      = 3'd1,
        VideoGuard         = 3'd2,
        VideoActive        = 3'd3,
        DataIslandPreamble = 3'd4,
        DataIslandGuard    = 3'd5,
        DataIslandActive   = 3'd6
    } period_t;

endpackage

// File: rtl/h14rx_decoding.sv
// HDMI 1.4 per-channel TMDS/TERC4/control symbol decoder with period recovery; 1-cycle registered latency, holds on !sym_valid.
// Optional running-disparity check in video active: define H14RX_DISPARITY_CHECK_EN.
module h14rx_decoding
    import h14tx_pkg::*;
#(
    parameter int Chan = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sym,
    input  logic       sym_valid,
    input  logic [3:0] pre_ctl,
    output period_t    period,
    output logic [1:0] ctl,
    output logic [3:0] data,
    output logic [7:0] video,
    output logic       out_valid,
    output logic       code_err
);

    typedef enum logic [2:0] {
        CTRL,
        V_GUARD,
        V_ACT,
        D_GUARD_L,
        D_ACT,
        D_GUARD_T
    } state_t;

    localparam logic [9:0] VidGuardSym = (Chan == 1) ? 10'b0100110011 : 10'b1011001100;
    localparam logic [9:0] DiGuardSym  = 10'b0100110011;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] pre_hold_q, pre_hold_d;
    period_t    period_q, period_d;
    logic [1:0] ctl_q, ctl_d;
    logic [3:0] data_q, data_d;
    logic [7:0] video_q, video_d;
    logic       out_valid_q;
    logic       code_err_q, code_err_d;

    logic       is_ctl;
    logic [1:0] ctl_dec;
    logic       is_terc4;
    logic [3:0] terc4_val;
    logic       is_vguard;
    logic       is_dguard;
    logic [3:0] cnt_upd;
    logic       vid_pre;
    logic       di_pre;
    period_t    ctl_period;

    function automatic logic [7:0] tmds_dec(input logic [9:0] q);
        logic [7:0] b;
        logic [7:0] d;
        b    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = b[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
        end
        return d;
    endfunction

    always_comb begin
        is_ctl  = 1'b1;
        ctl_dec = 2'b00;
        case (sym)
            10'b1101010100: ctl_dec = 2'b00;
            10'b0010101011: ctl_dec = 2'b01;
            10'b0101010100: ctl_dec = 2'b10;
            10'b1010101011: ctl_dec = 2'b11;
            default:        is_ctl  = 1'b0;
        endcase
    end

    always_comb begin
        is_terc4  = 1'b1;
        terc4_val = 4'h0;
        case (sym)
            10'b1010011100: terc4_val = 4'h0;
            10'b1001100011: terc4_val = 4'h1;
            10'b1011100100: terc4_val = 4'h2;
            10'b1011100010: terc4_val = 4'h3;
            10'b0101110001: terc4_val = 4'h4;
            10'b0100011110: terc4_val = 4'h5;
            10'b0110001110: terc4_val = 4'h6;
            10'b0100111100: terc4_val = 4'h7;
            10'b1011001100: terc4_val = 4'h8;
            10'b0100111001: terc4_val = 4'h9;
            10'b0110011100: terc4_val = 4'hA;
            10'b1011000110: terc4_val = 4'hB;
            10'b1010001110: terc4_val = 4'hC;
            10'b1001110001: terc4_val = 4'hD;
            10'b0101100011: terc4_val = 4'hE;
            10'b1011000011: terc4_val = 4'hF;
            default:        is_terc4  = 1'b0;
        endcase
    end

    // Channel 0 carries HSYNC/VSYNC inside its island guard, so any TERC4 0xC..0xF qualifies.
    always_comb begin
        is_vguard = (sym == VidGuardSym);
        if (Chan == 0) begin
            is_dguard = is_terc4 && (terc4_val[3:2] == 2'b11);
        end else begin
            is_dguard = (sym == DiGuardSym);
        end
    end

    always_comb begin
        if (pre_ctl != pre_hold_q) begin
            cnt_upd = 4'd1;
        end else if (count_q >= 4'd8) begin
            cnt_upd = 4'd8;
        end else begin
            cnt_upd = count_q + 4'd1;
        end
        vid_pre = (count_q >= 4'd8) && (pre_hold_q == 4'b0001);
        di_pre  = (count_q >= 4'd8) && (pre_hold_q == 4'b0101);
        if ((cnt_upd >= 4'd8) && (pre_ctl == 4'b0001)) begin
            ctl_period = VideoPreamble;
        end else if ((cnt_upd >= 4'd8) && (pre_ctl == 4'b0101)) begin
            ctl_period = DataIslandPreamble;
        end else begin
            ctl_period = Control;
        end
    end

`ifdef H14RX_DISPARITY_CHECK_EN
    logic signed [5:0] disp_q, disp_d;
    logic signed [5:0] sym_bal;
    logic signed [5:0] disp_sum;

    always_comb begin
        sym_bal  = $signed({1'b0, 4'($countones(sym)), 1'b0}) - 6'sd10;
        disp_sum = disp_q + sym_bal;
    end
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_hold_d = pre_hold_q;
        period_d   = period_q;
        ctl_d      = ctl_q;
        data_d     = data_q;
        video_d    = video_q;
        code_err_d = 1'b0;
`ifdef H14RX_DISPARITY_CHECK_EN
        disp_d     = disp_q;
`endif
        if (sym_valid) begin
            case (state_q)
                CTRL: begin
                    if (is_ctl) begin
                        ctl_d      = ctl_dec;
                        count_d    = cnt_upd;
                        pre_hold_d = pre_ctl;
                        period_d   = ctl_period;
                    end else if (is_vguard && vid_pre) begin
                        state_d  = V_GUARD;
                        count_d  = 4'd0;
                        period_d = VideoGuard;
                    end else if (is_dguard && di_pre) begin
                        state_d  = D_GUARD_L;
                        count_d  = 4'd0;
                        period_d = DataIslandGuard;
                    end else begin
                        code_err_d = 1'b1;
                        count_d    = 4'd0;
                        period_d   = Control;
                    end
                end
                V_GUARD: begin
                    if (is_vguard) begin
                        state_d  = V_ACT;
                        period_d = VideoGuard;
`ifdef H14RX_DISPARITY_CHECK_EN
                        disp_d   = 6'sd0;
`endif
                    end else begin
                        state_d    = CTRL;
                        count_d    = 4'd0;
                        period_d   = Control;
                        code_err_d = 1'b1;
                    end
                end
                V_ACT: begin
                    if (is_ctl) begin
                        state_d    = CTRL;
                        ctl_d      = ctl_dec;
                        count_d    = 4'd1;
                        pre_hold_d = pre_ctl;
                        period_d   = Control;
                    end else begin
                        video_d  = tmds_dec(sym);
                        period_d = VideoActive;
`ifdef H14RX_DISPARITY_CHECK_EN
                        if ((disp_sum > 6'sd10) || (disp_sum < -6'sd10)) begin
                            code_err_d = 1'b1;
                            disp_d     = 6'sd0;
                        end else begin
                            disp_d = disp_sum;
                        end
`endif
                    end
                end
                D_GUARD_L: begin
                    if (is_dguard) begin
                        state_d  = D_ACT;
                        period_d = DataIslandGuard;
                    end else begin
                        state_d    = CTRL;
                        count_d    = 4'd0;
                        period_d   = Control;
                        code_err_d = 1'b1;
                    end
                end
                D_ACT: begin
                    if (is_dguard) begin
                        state_d  = D_GUARD_T;
                        period_d = DataIslandGuard;
                    end else if (is_ctl) begin
                        state_d    = CTRL;
                        count_d    = 4'd0;
                        period_d   = Control;
                        code_err_d = 1'b1;
                    end else if (is_terc4) begin
                        data_d   = terc4_val;
                        period_d = DataIslandActive;
                    end else begin
                        code_err_d = 1'b1;
                        period_d   = DataIslandActive;
                    end
                end
                D_GUARD_T: begin
                    if (is_ctl) begin
                        state_d    = CTRL;
                        ctl_d      = ctl_dec;
                        count_d    = 4'd1;
                        pre_hold_d = pre_ctl;
                        period_d   = Control;
                    end else if (is_dguard) begin
                        period_d = DataIslandGuard;
                    end else begin
                        state_d    = CTRL;
                        count_d    = 4'd0;
                        period_d   = Control;
                        code_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d  = CTRL;
                    count_d  = 4'd0;
                    period_d = Control;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CTRL;
            count_q     <= 4'd0;
            pre_hold_q  <= 4'd0;
            period_q    <= Control;
            ctl_q       <= 2'b00;
            data_q      <= 4'h0;
            video_q     <= 8'h00;
            out_valid_q <= 1'b0;
            code_err_q  <= 1'b0;
`ifdef H14RX_DISPARITY_CHECK_EN
            disp_q      <= 6'sd0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pre_hold_q  <= pre_hold_d;
            period_q    <= period_d;
            ctl_q       <= ctl_d;
            data_q      <= data_d;
            video_q     <= video_d;
            out_valid_q <= sym_valid;
            code_err_q  <= code_err_d;
`ifdef H14RX_DISPARITY_CHECK_EN
            disp_q      <= disp_d;
`endif
        end
    end

    assign period    = period_q;
    assign ctl       = ctl_q;
    assign data      = data_q;
    assign video     = video_q;
    assign out_valid = out_valid_q;
    assign code_err  = code_err_q;

endmodule

// File: tb/tb_h14rx_decoding.sv
// Drives a channel-0 and a channel-1 decoder with the same symbol stream and checks both against a symbol-level model every cycle.
module tb_h14rx_decoding;
    import h14tx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sym = '0;
    logic       sym_valid = 1'b0;
    logic [3:0] pre_ctl = '0;

    period_t    per_o [2];
    logic [1:0] ctl_o [2];
    logic [3:0] dat_o [2];
    logic [7:0] vid_o [2];
    logic       ov_o  [2];
    logic       err_o [2];

    always #5 clk = ~clk;

    h14rx_decoding #(.Chan(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sym(sym), .sym_valid(sym_valid), .pre_ctl(pre_ctl),
        .period(per_o[0]), .ctl(ctl_o[0]), .data(dat_o[0]), .video(vid_o[0]),
        .out_valid(ov_o[0]), .code_err(err_o[0])
    );

    h14rx_decoding #(.Chan(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sym(sym), .sym_valid(sym_valid), .pre_ctl(pre_ctl),
        .period(per_o[1]), .ctl(ctl_o[1]), .data(dat_o[1]), .video(vid_o[1]),
        .out_valid(ov_o[1]), .code_err(err_o[1])
    );

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] VG0 = 10'b1011001100;
    localparam logic [9:0] VG1 = 10'b0100110011;
    localparam logic [9:0] DG  = 10'b0100110011;

    localparam int PH_CTL = 0, PH_VG = 1, PH_VA = 2, PH_DGL = 3, PH_DA = 4, PH_DGT = 5;

    logic [9:0] ctl_tab [4];
    logic [9:0] terc_tab [16];

    int         m_ph   [2];
    int         m_run  [2];
    logic [3:0] m_last [2];
    period_t    e_per  [2];
    logic [1:0] e_ctl  [2];
    logic [3:0] e_dat  [2];
    logic [7:0] e_vid  [2];
    logic       e_ov   [2];
    logic       e_err  [2];

    int total = 0;
    int bad   = 0;

    function automatic int ctl_of(input logic [9:0] s);
        for (int i = 0; i < 4; i++) if (ctl_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic int terc_of(input logic [9:0] s);
        for (int i = 0; i < 16; i++) if (terc_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [7:0] vid_of(input logic [9:0] s);
        logic [7:0] b;
        logic [7:0] d;
        b = s[9] ? ~s[7:0] : s[7:0];
        for (int i = 0; i < 8; i++) d[i] = (i == 0) ? b[0] : (b[i] ^ b[i-1] ^ ~s[8]);
        return d;
    endfunction

    task automatic bail(input int k);
        m_ph[k]  = PH_CTL;
        m_run[k] = 0;
        e_err[k] = 1'b1;
        e_per[k] = Control;
    endtask

    task automatic enter_ctl(input int k, input int c, input logic [3:0] p);
        m_ph[k]   = PH_CTL;
        m_run[k]  = 1;
        m_last[k] = p;
        e_ctl[k]  = 2'(c);
        e_per[k]  = Control;
    endtask

    task automatic model_step(input int k, input logic r, input logic v,
                              input logic [9:0] s, input logic [3:0] p);
        int c;
        int t;
        bit vg;
        bit dg;
        if (!r) begin
            m_ph[k] = PH_CTL; m_run[k] = 0; m_last[k] = 4'd0;
            e_per[k] = Control; e_ctl[k] = 2'd0; e_dat[k] = 4'd0; e_vid[k] = 8'd0;
            e_ov[k] = 1'b0; e_err[k] = 1'b0;
            return;
        end
        e_ov[k]  = v;
        e_err[k] = 1'b0;
        if (!v) return;
        c  = ctl_of(s);
        t  = terc_of(s);
        vg = (s == ((k == 1) ? VG1 : VG0));
        dg = (k == 0) ? (t >= 12) : (s == DG);
        case (m_ph[k])
            PH_CTL: begin
                if (c >= 0) begin
                    m_run[k]  = (p == m_last[k]) ? ((m_run[k] >= 8) ? 8 : m_run[k] + 1) : 1;
                    m_last[k] = p;
                    e_ctl[k]  = 2'(c);
                    if (m_run[k] >= 8 && p == 4'd1) e_per[k] = VideoPreamble;
                    else if (m_run[k] >= 8 && p == 4'd5) e_per[k] = DataIslandPreamble;
                    else e_per[k] = Control;
                end else if (vg && m_run[k] >= 8 && m_last[k] == 4'd1) begin
                    m_ph[k] = PH_VG; m_run[k] = 0; e_per[k] = VideoGuard;
                end else if (dg && m_run[k] >= 8 && m_last[k] == 4'd5) begin
                    m_ph[k] = PH_DGL; m_run[k] = 0; e_per[k] = DataIslandGuard;
                end else begin
                    bail(k);
                end
            end
            PH_VG:  if (vg) begin m_ph[k] = PH_VA; e_per[k] = VideoGuard; end else bail(k);
            PH_VA:  if (c >= 0) enter_ctl(k, c, p);
                    else begin e_vid[k] = vid_of(s); e_per[k] = VideoActive; end
            PH_DGL: if (dg) begin m_ph[k] = PH_DA; e_per[k] = DataIslandGuard; end else bail(k);
            PH_DA: begin
                if (dg) begin m_ph[k] = PH_DGT; e_per[k] = DataIslandGuard; end
                else if (c >= 0) bail(k);
                else if (t >= 0) begin e_dat[k] = 4'(t); e_per[k] = DataIslandActive; end
                else begin e_err[k] = 1'b1; e_per[k] = DataIslandActive; end
            end
            default: begin
                if (c >= 0) enter_ctl(k, c, p);
                else if (dg) e_per[k] = DataIslandGuard;
                else bail(k);
            end
        endcase
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s ch%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("out_valid", k, 32'(ov_o[k]),  32'(e_ov[k]));
            chk("code_err",  k, 32'(err_o[k]), 32'(e_err[k]));
            chk("period",    k, 32'(per_o[k]), 32'(e_per[k]));
            chk("ctl",       k, 32'(ctl_o[k]), 32'(e_ctl[k]));
            chk("data",      k, 32'(dat_o[k]), 32'(e_dat[k]));
            chk("video",     k, 32'(vid_o[k]), 32'(e_vid[k]));
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [9:0] s, input logic [3:0] p);
        rst_n = r; sym_valid = v; sym = s; pre_ctl = p;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, v, s, p);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ctl_run(input logic [9:0] s, input logic [3:0] p, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, s, p);
    endtask

    initial begin
        ctl_tab[0] = C00; ctl_tab[1] = C01; ctl_tab[2] = C10; ctl_tab[3] = C11;
        terc_tab[0]  = 10'b1010011100; terc_tab[1]  = 10'b1001100011;
        terc_tab[2]  = 10'b1011100100; terc_tab[3]  = 10'b1011100010;
        terc_tab[4]  = 10'b0101110001; terc_tab[5]  = 10'b0100011110;
        terc_tab[6]  = 10'b0110001110; terc_tab[7]  = 10'b0100111100;
        terc_tab[8]  = 10'b1011001100; terc_tab[9]  = 10'b0100111001;
        terc_tab[10] = 10'b0110011100; terc_tab[11] = 10'b1011000110;
        terc_tab[12] = 10'b1010001110; terc_tab[13] = 10'b1001110001;
        terc_tab[14] = 10'b0101100011; terc_tab[15] = 10'b1011000011;

        // reset state
        cycle(1'b0, 1'b0, 10'h3FF, 4'hF);
        cycle(1'b0, 1'b1, C11, 4'h0);
        chk("rst_period", 0, 32'(per_o[0]), 32'(Control));
        chk("rst_valid", 1, 32'(ov_o[1]), 32'd0);

        // first control symbol after reset
        cycle(1'b1, 1'b1, C00, 4'h0);
        chk("first_valid", 0, 32'(ov_o[0]), 32'd1);
        chk("first_ctl", 0, 32'(ctl_o[0]), 32'd0);

        // video preamble, guard, active, exit on control
        ctl_run(C00, 4'b0001, 8);
        chk("vpre", 0, 32'(per_o[0]), 32'(VideoPreamble));
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        chk("vguard1", 0, 32'(per_o[0]), 32'(VideoGuard));
        chk("ch1_bad_vguard", 1, 32'(err_o[1]), 32'd1);
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        chk("vguard2", 0, 32'(per_o[0]), 32'(VideoGuard));
        cycle(1'b1, 1'b1, 10'b0100000000, 4'b0001);
        chk("vact", 0, 32'(per_o[0]), 32'(VideoActive));
        chk("vid_00", 0, 32'(vid_o[0]), 32'h00);
        cycle(1'b1, 1'b1, 10'b1000000000, 4'b0001);
        chk("vid_ff", 0, 32'(vid_o[0]), 32'hFF);
        cycle(1'b1, 1'b1, 10'b0111110000, 4'b0001);
        cycle(1'b1, 1'b1, 10'b1100011010, 4'b0001);
        cycle(1'b1, 1'b1, C10, 4'b0000);
        chk("vexit_ctl", 0, 32'(ctl_o[0]), 32'd2);
        chk("vexit_per", 0, 32'(per_o[0]), 32'(Control));

        // guard after a short preamble
        ctl_run(C00, 4'b0001, 5);
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        chk("short_pre_err", 0, 32'(err_o[0]), 32'd1);
        chk("short_pre_per", 0, 32'(per_o[0]), 32'(Control));

        // data island on channel 1
        ctl_run(C00, 4'b0101, 8);
        chk("dpre", 1, 32'(per_o[1]), 32'(DataIslandPreamble));
        cycle(1'b1, 1'b1, DG, 4'b0101);
        cycle(1'b1, 1'b1, DG, 4'b0101);
        chk("dguard2", 1, 32'(per_o[1]), 32'(DataIslandGuard));
        cycle(1'b1, 1'b1, terc_tab[7], 4'b0101);
        chk("dact", 1, 32'(per_o[1]), 32'(DataIslandActive));
        chk("data7", 1, 32'(dat_o[1]), 32'h7);
        cycle(1'b1, 1'b1, DG, 4'b0101);
        chk("dtrail", 1, 32'(per_o[1]), 32'(DataIslandGuard));
        cycle(1'b1, 1'b1, C11, 4'b0000);
        chk("dexit", 1, 32'(per_o[1]), 32'(Control));
        chk("dexit_ctl", 1, 32'(ctl_o[1]), 32'd3);

        // stall inside data island active, bad symbols, then resume
        ctl_run(C00, 4'b0101, 9);
        cycle(1'b1, 1'b1, DG, 4'b0101);
        cycle(1'b1, 1'b1, DG, 4'b0101);
        cycle(1'b1, 1'b1, terc_tab[3], 4'b0101);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, C01, 4'b0000);
            chk("stall_valid", 1, 32'(ov_o[1]), 32'd0);
            chk("stall_data", 1, 32'(dat_o[1]), 32'h3);
        end
        cycle(1'b1, 1'b1, terc_tab[10], 4'b0101);
        chk("resume_data", 1, 32'(dat_o[1]), 32'hA);
        cycle(1'b1, 1'b1, 10'b1111111111, 4'b0101);
        chk("non_terc4", 1, 32'(err_o[1]), 32'd1);
        cycle(1'b1, 1'b1, terc_tab[5], 4'b0101);
        cycle(1'b1, 1'b1, C00, 4'b0101);
        chk("dact_ctl_err", 1, 32'(err_o[1]), 32'd1);
        cycle(1'b1, 1'b1, C00, 4'b0000);

        // reset mid video active
        ctl_run(C00, 4'b0001, 10);
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        cycle(1'b1, 1'b1, 10'b1000000000, 4'b0001);
        cycle(1'b0, 1'b1, 10'b0111100001, 4'b0001);
        chk("mid_rst_vid", 0, 32'(vid_o[0]), 32'h00);
        chk("mid_rst_per", 0, 32'(per_o[0]), 32'(Control));
        cycle(1'b1, 1'b1, C01, 4'b0000);
        chk("post_rst_ctl", 0, 32'(ctl_o[0]), 32'd1);
        chk("post_rst_per", 0, 32'(per_o[0]), 32'(Control));

        // broken guard pair
        ctl_run(C00, 4'b0001, 8);
        cycle(1'b1, 1'b1, VG0, 4'b0001);
        cycle(1'b1, 1'b1, 10'b0111110000, 4'b0001);
        chk("vguard_break", 0, 32'(err_o[0]), 32'd1);
        ctl_run(C10, 4'b0000, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
